// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD digit feeder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    WRITE,
    DONE
  } state_t;

  // Written on digits blanked by leading-zero suppression.
  localparam logic [3:0] BLANK_CODE = 4'hF;
  // Written on every digit when the value does not fit the display.
  localparam logic [3:0] SAT_DIGIT  = 4'h9;

  // Largest value representable with n decimal digits (10^n - 1).
  function automatic logic [63:0] max_bcd_value(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] res
);

  assign res = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bcd_digit_feeder.sv
// Converts a binary value to BCD with an iterative shift-and-add-3 engine and
// streams one digit per cycle into the display driver's digit-write port.
// Optional build macro BCD_DIGIT_FEEDER_BLANK_EN enables leading-zero blanking.
//
// Start handshake: i_w_start is a request that is taken only while the FSM is
// in IDLE (o_w_busy=0 and o_w_done=0); a request in any other cycle is dropped,
// never queued. i_w_value is sampled on the accepting edge only. Each accepted
// start produces exactly DIGITS write strobes followed by one o_w_done pulse.
module bcd_digit_feeder
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 8,   // must not exceed 2**SELW
  parameter int SELW   = 3
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic [WIDTH-1:0] i_w_value,
  input  logic             i_w_start,
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic             o_w_ovf,
  output logic [SELW-1:0]  o_w_sel,
  output logic [3:0]       o_w_dig,
  output logic             o_w_we,
  output state_t           o_w_state
);

  localparam int          BW      = 4 * DIGITS;
  localparam int          CW      = $clog2(WIDTH + 1);
  localparam logic [63:0] MAX_VAL = max_bcd_value(DIGITS);

  state_t            state;
  logic [WIDTH-1:0]  bin;
  logic [WIDTH-1:0]  bin_nxt;
  logic [BW-1:0]     bcd;
  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_nxt;
  logic [CW-1:0]     cnt;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] blank_nxt;
  logic [SELW-1:0]   sel_nxt;

  assign o_w_state = state;
  assign sel_nxt   = o_w_sel + SELW'(1);

  // Per-nibble +3 correction ahead of each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib (bcd[4*g +: 4]),
      .res (bcd_adj[4*g +: 4])
    );
  end

  assign {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;

  // Blank mask from the accumulator value that will be final after this shift.
  always_comb begin
    blank_nxt = '0;
`ifdef BCD_DIGIT_FEEDER_BLANK_EN
    begin : blank_scan
      logic seen;
      seen = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (bcd_nxt[4*i +: 4] != 4'd0) seen = 1'b1;
        blank_nxt[i] = ~seen;
      end
    end
`endif
  end

  // Digit code for one select index: saturation wins over blanking.
  function automatic logic [3:0] pick(input logic [BW-1:0]     b,
                                      input logic [DIGITS-1:0] m,
                                      input logic [SELW-1:0]   idx,
                                      input logic              sat);
    if (sat) return SAT_DIGIT;
    if (m[idx]) return BLANK_CODE;
    return b[4*idx +: 4];
  endfunction

  // Control FSM; every output is registered and changes with the state.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state    <= IDLE;
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      blank    <= '0;
      o_w_busy <= 1'b0;
      o_w_done <= 1'b0;
      o_w_ovf  <= 1'b0;
      o_w_sel  <= '0;
      o_w_dig  <= '0;
      o_w_we   <= 1'b0;
    end else begin
      o_w_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_w_start) begin
            bin      <= i_w_value;
            bcd      <= '0;
            cnt      <= '0;
            o_w_ovf  <= (64'(i_w_value) > MAX_VAL);
            o_w_busy <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          bin <= bin_nxt;
          bcd <= bcd_nxt;
          cnt <= cnt + CW'(1);
          // Last shift: the first write goes out on the same edge.
          if (cnt == CW'(WIDTH - 1)) begin
            blank   <= blank_nxt;
            o_w_we  <= 1'b1;
            o_w_sel <= '0;
            o_w_dig <= pick(bcd_nxt, blank_nxt, '0, o_w_ovf);
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (o_w_sel == SELW'(DIGITS - 1)) begin
            o_w_we   <= 1'b0;
            o_w_busy <= 1'b0;
            o_w_done <= 1'b1;
            state    <= DONE;
          end else begin
            o_w_sel <= sel_nxt;
            o_w_dig <= pick(bcd, blank, sel_nxt, o_w_ovf);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Bench for bcd_digit_feeder. Build with BCD_DIGIT_FEEDER_BLANK_EN defined to
// exercise the leading-zero blanking variant; expectations follow the macro.
module tb_bcd_digit_feeder;
  import bcd_pkg::*;

  localparam int W  = 27;
  localparam int D  = 8;
  localparam int S  = 3;
  localparam int EW = 32 + S + 4;
`ifdef BCD_DIGIT_FEEDER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] value = '0;
  logic         busy, done, ovf, we;
  logic [S-1:0] sel;
  logic [3:0]   dig;
  state_t       state;

  bcd_digit_feeder #(.WIDTH(W), .DIGITS(D), .SELW(S)) dut (
    .i_w_clk   (clk),
    .i_w_reset (reset),
    .i_w_value (value),
    .i_w_start (start),
    .o_w_busy  (busy),
    .o_w_done  (done),
    .o_w_ovf   (ovf),
    .o_w_sel   (sel),
    .o_w_dig   (dig),
    .o_w_we    (we),
    .o_w_state (state)
  );

  initial forever #5 clk = ~clk;

  int   cyc      = 0;
  logic rst_edge = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  logic [EW-1:0] exp_q[$];
  int            done_q[$];
  int            bs = 1, be = 0;
  int            ovf_from = -1;
  logic          ovf_pend = 1'b0;
  logic          ovf_m = 1'b0;
  logic [S-1:0]  held_sel = '0;
  logic [3:0]    held_dig = '0;
  logic [3:0]    wr_dig[D];
  int            n_wr = 0, n_done = 0, last_done = -1;

  // Decimal digit i of v as the display should show it.
  function automatic logic [3:0] exp_digit(input longint v, input int i);
    longint p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (v > 99999999) return 4'h9;
    if (BLANK_EN && i > 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  // Record what an accepted start in the current cycle must produce.
  task automatic accept(input longint v);
    for (int i = 0; i < D; i++)
      exp_q.push_back({32'(cyc + W + 1 + i), S'(i), exp_digit(v, i)});
    done_q.push_back(cyc + W + D + 1);
    bs       = cyc + 1;
    be       = cyc + W + D;
    ovf_pend = (v > 99999999);
    ovf_from = cyc + 1;
  endtask

  // Compare process: every cycle, mid-period.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_edge) begin
        exp_q.delete();
        done_q.delete();
        bs = 1; be = 0; ovf_m = 1'b0; ovf_from = -1;
        held_sel = '0; held_dig = '0;
        check("reset_outputs", {busy, done, ovf, we, sel, dig}, '0);
        check("reset_state", 64'(state), 64'(IDLE));
      end else begin
        if (cyc == ovf_from) ovf_m = ovf_pend;
        check("busy", busy, 64'((cyc >= bs) && (cyc <= be)));
        check("ovf", ovf, ovf_m);
        if (we) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("write_cyc_sel_dig", {32'(cyc), sel, dig}, e);
            held_sel = e[6:4];
            held_dig = e[3:0];
          end
          wr_dig[sel] = dig;
          n_wr++;
        end else begin
          check("hold_sel_dig", {sel, dig}, {held_sel, held_dig});
        end
        while (exp_q.size() > 0 && int'(exp_q[0][EW-1:7]) < cyc) begin
          e = exp_q.pop_front();
          check("missing_write", 0, 1);
        end
        if (done) begin
          n_done++;
          last_done = cyc;
          if (done_q.size() == 0) check("unexpected_done", 1, 0);
          else check("done_cycle", cyc, done_q.pop_front());
        end
        while (done_q.size() > 0 && done_q[0] < cyc) begin
          void'(done_q.pop_front());
          check("missing_done", 0, 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic reset_counts();
    n_wr = 0;
    n_done = 0;
    for (int i = 0; i < D; i++) wr_dig[i] = 4'hE;
  endtask

  task automatic pulse(input longint v, input bit accepted);
    start = 1'b1;
    value = W'(v);
    if (accepted) accept(v);
    tick();
    start = 1'b0;
  endtask

  task automatic check_digits(input string name, input logic [31:0] exp);
    logic [31:0] got;
    for (int i = 0; i < D; i++) got[4*i +: 4] = wr_dig[i];
    check(name, got, exp);
  endtask

  // Full conversion of v, then literal checks on the captured writes.
  task automatic run(input longint v, input logic [31:0] exp_digits, input logic exp_ovf);
    int acc;
    reset_counts();
    acc = cyc;
    pulse(v, 1'b1);
    go_to(acc + W + D + 4);
    check_digits("digits", exp_digits);
    check("write_count", n_wr, D);
    check("done_latency", last_done - acc, 36);
    check("ovf_after_done", ovf, exp_ovf);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    run(12345678, 32'h12345678, 1'b0);
    run(0, BLANK_EN ? 32'hFFFFFFF0 : 32'h00000000, 1'b0);
    run(99999999, 32'h99999999, 1'b0);
    run(100000000, 32'h99999999, 1'b1);
    run(1000, BLANK_EN ? 32'hFFFF1000 : 32'h00001000, 1'b0);
    run(90909090, 32'h90909090, 1'b0);
    run(134217727, 32'h99999999, 1'b1);

    // Starts during CONV, WRITE and the DONE cycle are dropped.
    reset_counts();
    acc = cyc;
    pulse(42, 1'b1);
    go_to(acc + 5);
    pulse(999, 1'b0);
    go_to(acc + 30);
    pulse(555, 1'b0);
    go_to(acc + 36);
    pulse(777, 1'b0);
    check("ignored_write_count", n_wr, 8);
    check("ignored_done_count", n_done, 1);
    check_digits("digits_42", BLANK_EN ? 32'hFFFFFF42 : 32'h00000042);
    // First IDLE cycle after DONE accepts.
    check("restart_cycle", cyc - acc, 37);
    reset_counts();
    acc = cyc;
    pulse(7, 1'b1);
    go_to(acc + W + D + 4);
    check_digits("digits_7", BLANK_EN ? 32'hFFFFFFF7 : 32'h00000007);
    check("restart_write_count", n_wr, 8);

    // Reset in cycle 30 of a conversion, mid-WRITE.
    reset_counts();
    acc = cyc;
    pulse(12345678, 1'b1);
    go_to(acc + 30);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_we", we, 0);
    check("abort_busy", busy, 0);
    go_to(acc + 45);
    check("abort_no_done", n_done, 0);
    check("abort_writes", n_wr, 3);
    run(12345678, 32'h12345678, 1'b0);

    check("queues_drained", exp_q.size() + done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
